vend_controller: RTL and testbench

Transaction sequencer for the vending datapath. It accumulates 1- and 2-rupee coins into a credit register and accepts an item selection against a per-item price table. It drives the item dispenser through a req/ack handshake and pays out change or refunds as one-rupee pulses. It sits between the coin acceptor / keypad front end and the dispenser / change-hopper actuators.

---
 rtl/vend_pkg.sv | 18 +
 rtl/vend_change_pulser.sv | 45 ++++
 rtl/vend_controller.sv | 171 +++++++++++++++++
 tb/tb_vend_controller.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and coin encodings for the vending transaction sequencer.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CREDIT   = 2'd1,
        DISPENSE = 2'd2,
        CHANGE   = 2'd3
    } vend_state_e;

    localparam logic [1:0] COIN_ONE = 2'd1;
    localparam logic [1:0] COIN_TWO = 2'd2;

    function automatic logic coin_is_valid(input logic [1:0] value);
        return (value == COIN_ONE) || (value == COIN_TWO);
    endfunction

endpackage

// File: rtl/vend_change_pulser.sv
// Pays out a loaded rupee amount as a high-1/low-1 pulse train; done marks the
// low cycle that follows the final pulse.
module vend_change_pulser #(
    parameter int unsigned W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] amount_i,
    output logic         pulse_o,
    output logic         done_o
);

    logic [W-1:0] change_due_q;
    logic         pulse_q;
    logic         active_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            change_due_q <= '0;
            pulse_q      <= 1'b0;
            active_q     <= 1'b0;
        end else if (load_i) begin
            // The first pulse is emitted in the cycle right after the load edge.
            active_q     <= (amount_i != '0);
            pulse_q      <= (amount_i != '0);
            change_due_q <= (amount_i != '0) ? amount_i - W'(1) : '0;
        end else if (active_q) begin
            if (pulse_q) begin
                pulse_q <= 1'b0;
            end else if (change_due_q != '0) begin
                pulse_q      <= 1'b1;
                change_due_q <= change_due_q - W'(1);
            end else begin
                active_q <= 1'b0;
            end
        end
    end

    assign pulse_o = pulse_q;
    assign done_o  = active_q & ~pulse_q & (change_due_q == '0);

endmodule

// File: rtl/vend_controller.sv
// Vending transaction sequencer: coin credit, priced selection, dispenser
// handshake and change payout. Define VEND_CTRL_TIMEOUT_EN for inactivity refund.
module vend_controller
    import vend_pkg::*;
#(
    parameter int unsigned NUM_ITEMS      = 4,
    parameter int unsigned PRICE_W        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         coin_valid,
    input  logic [1:0]                   coin_value,
    input  logic                         sel_valid,
    input  logic [$clog2(NUM_ITEMS)-1:0] sel_item,
    input  logic [NUM_ITEMS*PRICE_W-1:0] price_cfg,
    input  logic                         cancel,
    input  logic                         disp_ack,
    output logic                         disp_req,
    output logic [$clog2(NUM_ITEMS)-1:0] disp_item,
    output logic                         change_pulse,
    output logic                         coin_reject,
    output logic [PRICE_W-1:0]           credit,
    output logic                         busy
);

    localparam int unsigned SEL_W = $clog2(NUM_ITEMS);

    if (NUM_ITEMS < 2 || TIMEOUT_CYCLES < 2) begin : g_cfg_check
        $error("vend_controller: NUM_ITEMS and TIMEOUT_CYCLES must both be >= 2");
    end

    vend_state_e        state_q;
    logic [PRICE_W-1:0] credit_q;
    logic [PRICE_W-1:0] price_q;
    logic [SEL_W-1:0]   disp_item_q;
    logic               disp_req_q;
    logic               coin_reject_q;
    logic               busy_q;

    // Unused index slots read as price 0, so they behave as disabled items.
    logic [PRICE_W-1:0] price_tbl [2**SEL_W];
    for (genvar k = 0; k < 2**SEL_W; k++) begin : g_price
        if (k < NUM_ITEMS) begin : g_used
            assign price_tbl[k] = price_cfg[k*PRICE_W +: PRICE_W];
        end else begin : g_unused
            assign price_tbl[k] = '0;
        end
    end

    logic               coin_ok;
    logic [PRICE_W:0]   credit_sum;
    logic               coin_fits;
    logic [PRICE_W-1:0] sel_price;
    logic               sel_ok;
    logic               timeout_fire;
    logic               cancel_eff;
    logic               pulse_load;
    logic [PRICE_W-1:0] pulse_amount;
    logic               pulse_done;

    assign coin_ok    = coin_valid & coin_is_valid(coin_value);
    assign credit_sum = (PRICE_W+1)'(credit_q) + (PRICE_W+1)'(coin_value);
    assign coin_fits  = ~credit_sum[PRICE_W];
    assign sel_price  = price_tbl[sel_item];
    assign sel_ok     = sel_valid && (sel_price != '0) && (credit_q >= sel_price);
    assign cancel_eff = cancel | timeout_fire;

`ifdef VEND_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] idle_cnt_q;

    assign timeout_fire = (state_q == CREDIT) && (idle_cnt_q == TO_W'(TIMEOUT_CYCLES));

    // Counts CREDIT cycles since entry or the last accepted coin.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else if (state_q != CREDIT || (coin_ok && coin_fits)) begin
            idle_cnt_q <= '0;
        end else if (!timeout_fire) begin
            idle_cnt_q <= idle_cnt_q + TO_W'(1);
        end
    end
`else
    assign timeout_fire = 1'b0;
`endif

    assign pulse_load   = ((state_q == CREDIT) && cancel_eff) || ((state_q == DISPENSE) && disp_ack);
    assign pulse_amount = (state_q == CREDIT) ? credit_q : credit_q - price_q;

    vend_change_pulser #(
        .W (PRICE_W)
    ) u_pulser (
        .clock    (clock),
        .reset    (reset),
        .load_i   (pulse_load),
        .amount_i (pulse_amount),
        .pulse_o  (change_pulse),
        .done_o   (pulse_done)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            price_q       <= '0;
            disp_item_q   <= '0;
            disp_req_q    <= 1'b0;
            coin_reject_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            // Malformed coins are bounced in every state; branches below add other rejects.
            coin_reject_q <= coin_valid & ~coin_is_valid(coin_value);
            unique case (state_q)
                IDLE: begin
                    if (coin_ok) begin
                        credit_q <= PRICE_W'(coin_value);
                        state_q  <= CREDIT;
                    end
                end
                CREDIT: begin
                    if (cancel_eff) begin
                        credit_q      <= '0;
                        busy_q        <= 1'b1;
                        coin_reject_q <= coin_valid;
                        state_q       <= CHANGE;
                    end else if (coin_ok) begin
                        if (coin_fits) credit_q <= credit_sum[PRICE_W-1:0];
                        else           coin_reject_q <= 1'b1;
                    end else if (sel_ok) begin
                        price_q     <= sel_price;
                        disp_item_q <= sel_item;
                        disp_req_q  <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= DISPENSE;
                    end
                end
                DISPENSE: begin
                    coin_reject_q <= coin_valid;
                    if (disp_ack) begin
                        credit_q   <= '0;
                        disp_req_q <= 1'b0;
                        if (credit_q != price_q) begin
                            state_q <= CHANGE;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                CHANGE: begin
                    coin_reject_q <= coin_valid;
                    if (pulse_done) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign disp_req    = disp_req_q;
    assign disp_item   = disp_item_q;
    assign coin_reject = coin_reject_q;
    assign credit      = credit_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vend_controller.sv
// Directed self-checking bench for vend_controller; inputs change and outputs
// are sampled on the falling clock edge.
module tb_vend_controller;

    localparam int unsigned NUM_ITEMS      = 4;
    localparam int unsigned PRICE_W        = 4;
    localparam int unsigned TIMEOUT_CYCLES = 10;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 coin_valid = 1'b0;
    logic [1:0]           coin_value = 2'd0;
    logic                 sel_valid = 1'b0;
    logic [1:0]           sel_item = 2'd0;
    logic [15:0]          price_cfg = 16'hF035;  // item3=15, item2=0 (off), item1=3, item0=5
    logic                 cancel = 1'b0;
    logic                 disp_ack = 1'b0;
    logic                 disp_req;
    logic [1:0]           disp_item;
    logic                 change_pulse;
    logic                 coin_reject;
    logic [PRICE_W-1:0]   credit;
    logic                 busy;

    int n_checks = 0;
    int n_fail   = 0;

    vend_controller #(
        .NUM_ITEMS      (NUM_ITEMS),
        .PRICE_W        (PRICE_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .sel_valid    (sel_valid),
        .sel_item     (sel_item),
        .price_cfg    (price_cfg),
        .cancel       (cancel),
        .disp_ack     (disp_ack),
        .disp_req     (disp_req),
        .disp_item    (disp_item),
        .change_pulse (change_pulse),
        .coin_reject  (coin_reject),
        .credit       (credit),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic coin(input logic [1:0] value);
        coin_valid = 1'b1;
        coin_value = value;
        tick();
        coin_valid = 1'b0;
        coin_value = 2'd0;
    endtask

    task automatic select(input logic [1:0] item);
        sel_valid = 1'b1;
        sel_item  = item;
        tick();
        sel_valid = 1'b0;
    endtask

    initial begin
        tick();
        check("rst_disp_req", disp_req, 0);
        check("rst_disp_item", disp_item, 0);
        check("rst_change_pulse", change_pulse, 0);
        check("rst_coin_reject", coin_reject, 0);
        check("rst_credit", credit, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        tick();

        // 2+2 rupees, buy item 1 (price 3), ack on the third request cycle
        coin(2'd2);
        check("a_credit2", credit, 2);
        check("a_no_reject", coin_reject, 0);
        coin(2'd2);
        check("a_credit4", credit, 4);
        select(2'd1);
        check("a_disp_req", disp_req, 1);
        check("a_disp_item", disp_item, 1);
        check("a_busy", busy, 1);
        check("a_credit_held", credit, 4);
        coin(2'd1);
        check("a_coin_in_dispense_rej", coin_reject, 1);
        check("a_coin_in_dispense_credit", credit, 4);
        check("a_req_held1", disp_req, 1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("a_cancel_ignored", disp_req, 1);
        disp_ack = 1'b1;
        tick();
        disp_ack = 1'b0;
        check("a_req_drop", disp_req, 0);
        check("a_pulse_hi", change_pulse, 1);
        check("a_credit_zero", credit, 0);
        check("a_busy_change", busy, 1);
        tick();
        check("a_pulse_lo", change_pulse, 0);
        check("a_busy_low_cycle", busy, 1);
        tick();
        check("a_idle_busy", busy, 0);
        check("a_idle_pulse", change_pulse, 0);

        // Malformed coin encodings are rejected in IDLE
        coin(2'd3);
        check("inv3_reject", coin_reject, 1);
        check("inv3_credit", credit, 0);
        coin(2'd0);
        check("inv0_reject", coin_reject, 1);
        check("inv0_credit", credit, 0);

        // Unaffordable and disabled selections, coin beats selection
        coin(2'd2);
        check("c_credit2", credit, 2);
        check("c_reject_clear", coin_reject, 0);
        select(2'd1);
        check("c_short_req", disp_req, 0);
        check("c_short_busy", busy, 0);
        check("c_short_credit", credit, 2);
        select(2'd2);
        check("c_disabled_req", disp_req, 0);
        check("c_disabled_credit", credit, 2);
        coin_valid = 1'b1;
        coin_value = 2'd1;
        sel_valid  = 1'b1;
        sel_item   = 2'd1;
        tick();
        coin_valid = 1'b0;
        sel_valid  = 1'b0;
        check("c_coin_wins_credit", credit, 3);
        check("c_coin_wins_req", disp_req, 0);

        // Cancel with a simultaneous coin: coin bounced, 3 rupees refunded over 6 cycles
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin_value = 2'd2;
        tick();
        cancel     = 1'b0;
        coin_valid = 1'b0;
        check("d_reject", coin_reject, 1);
        check("d_credit", credit, 0);
        check("d_pulse0", change_pulse, 1);
        check("d_busy0", busy, 1);
        for (int j = 1; j < 6; j++) begin
            tick();
            check($sformatf("d_pulse%0d", j), change_pulse, (j % 2 == 0) ? 1 : 0);
            check($sformatf("d_busy%0d", j), busy, 1);
        end
        tick();
        check("d_idle_busy", busy, 0);
        check("d_idle_pulse", change_pulse, 0);

        // Credit ceiling at 15, exact-price purchase with ack in the first request cycle
        for (int j = 0; j < 7; j++) coin(2'd2);
        check("b_credit14", credit, 14);
        coin(2'd2);
        check("b_over_by_1_reject", coin_reject, 1);
        check("b_over_by_1_credit", credit, 14);
        coin(2'd1);
        check("b_fill_reject", coin_reject, 0);
        check("b_credit15", credit, 15);
        coin(2'd1);
        check("b_full_reject", coin_reject, 1);
        check("b_full_credit", credit, 15);
        select(2'd3);
        check("b_disp_req", disp_req, 1);
        check("b_disp_item", disp_item, 3);
        disp_ack = 1'b1;
        tick();
        check("b_req_drop", disp_req, 0);
        check("b_no_change_busy", busy, 0);
        check("b_no_change_pulse", change_pulse, 0);
        check("b_credit0", credit, 0);
        tick();
        disp_ack = 1'b0;
        check("b_stray_ack_req", disp_req, 0);
        check("b_stray_ack_busy", busy, 0);

        // Inactivity: refund edge is 11 cycles after the coin when compiled in
        coin(2'd2);
        check("e_credit2", credit, 2);
`ifdef VEND_CTRL_TIMEOUT_EN
        for (int j = 1; j <= 11; j++) begin
            tick();
            check($sformatf("e_pulse_t%0d", j), change_pulse, (j == 11) ? 1 : 0);
            check($sformatf("e_credit_t%0d", j), credit, (j == 11) ? 0 : 2);
        end
`else
        for (int j = 1; j <= 11; j++) begin
            tick();
            check($sformatf("e_pulse_t%0d", j), change_pulse, 0);
            check($sformatf("e_credit_t%0d", j), credit, 2);
        end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("e_cancel_pulse", change_pulse, 1);
`endif
        tick();
        check("e_drain_lo1", change_pulse, 0);
        tick();
        check("e_drain_hi2", change_pulse, 1);
        tick();
        check("e_drain_lo2", change_pulse, 0);
        check("e_drain_busy", busy, 1);
        tick();
        check("e_idle_busy", busy, 0);

        // Reset in DISPENSE aborts without refund; next coin accepted normally
        coin(2'd2);
        coin(2'd2);
        select(2'd1);
        check("f_disp_req", disp_req, 1);
        reset = 1'b1;
        #1;
        check("f_rst_req", disp_req, 0);
        check("f_rst_credit", credit, 0);
        check("f_rst_busy", busy, 0);
        check("f_rst_item", disp_item, 0);
        tick();
        reset = 1'b0;
        check("f_no_refund", change_pulse, 0);
        coin(2'd1);
        check("f_credit1", credit, 1);
        check("f_no_reject", coin_reject, 0);
        check("f_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
